// File: rtl/subtask_scheduler.sv
// Subtask scheduler: hold-to-arm, one active subtask, cooldown after each run.
// Optional macro ROUND_ROBIN_EN selects circular candidate search from a pointer.
module subtask_scheduler #(
   parameter int NUM_TASKS      = 4,
   parameter int TICK_DIV       = 100_000_000,
   parameter int HOLD_TICKS     = 4,
   parameter int COOLDOWN_TICKS = 2,
   localparam int IW = $clog2(NUM_TASKS)
) (
   input  logic                 Master_Clock,
   input  logic                 Reset_n,
   input  logic [NUM_TASKS-1:0] sw_req,
   input  logic [NUM_TASKS-1:0] task_done,
   output logic [NUM_TASKS-1:0] task_active,
   output logic [NUM_TASKS-1:0] task_start,
   output logic [IW-1:0]        cur_task,
   output logic                 arming,
   output logic                 busy
);

   localparam int PW   = $clog2(TICK_DIV) + 1;
   localparam int MAXT = (HOLD_TICKS > COOLDOWN_TICKS) ?
                         HOLD_TICKS : COOLDOWN_TICKS;
   localparam int CW   = $clog2(MAXT) + 1;

   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] H_LAST = CW'(HOLD_TICKS - 1);
   localparam logic [CW-1:0] C_LAST =
      CW'((COOLDOWN_TICKS > 0) ? COOLDOWN_TICKS - 1 : 0);
   localparam bit C_ZERO = (COOLDOWN_TICKS == 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_COOL
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [PW-1:0]        r_presc;
   logic [CW-1:0]        r_cnt;
   logic [NUM_TASKS-1:0] r_lock;
   logic [IW-1:0]        r_cur;
   logic [NUM_TASKS-1:0] r_active;
   logic [NUM_TASKS-1:0] r_start;

   logic                 w_tick;
   logic                 w_enter;
   logic [NUM_TASKS-1:0] w_elig;
   logic                 w_found;
   logic [IW-1:0]        w_cand;
   logic [NUM_TASKS-1:0] w_onehot;
   logic [NUM_TASKS-1:0] w_lock_nxt;
   logic [NUM_TASKS-1:0] w_act_nxt;
   logic [NUM_TASKS-1:0] w_start_nxt;

`ifdef ROUND_ROBIN_EN
   logic [IW-1:0]        r_ptr;
`endif

   assign w_tick   = (r_presc == P_LAST);
   assign w_onehot = {{(NUM_TASKS-1){1'b0}}, 1'b1} << r_cur;
   assign w_enter  = (w_next != r_state) &&
                     (w_next == S_ARM || w_next == S_COOL);

   // Candidate selection among unlocked requests
   always_comb begin
      w_elig  = sw_req & ~r_lock;
      w_found = |w_elig;
      w_cand  = '0;
`ifdef ROUND_ROBIN_EN
      for (int i = NUM_TASKS - 1; i >= 0; i--) begin
         if (w_elig[(int'(r_ptr) + i) % NUM_TASKS])
            w_cand = IW'((int'(r_ptr) + i) % NUM_TASKS);
      end
`else
      for (int i = NUM_TASKS - 1; i >= 0; i--) begin
         if (w_elig[i])
            w_cand = IW'(i);
      end
`endif
   end

   // State register
   always_ff @(posedge Master_Clock or negedge Reset_n) begin
      if (!Reset_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_found)
               w_next = S_ARM;
         end
         S_ARM: begin
            if (!sw_req[r_cur])
               w_next = S_IDLE;
            else if (w_tick && r_cnt == H_LAST)
               w_next = S_RUN;
         end
         S_RUN: begin
            if (task_done[r_cur] || !sw_req[r_cur])
               w_next = S_COOL;
         end
         S_COOL: begin
            if (C_ZERO || (w_tick && r_cnt == C_LAST))
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Output decode and next values of registered outputs
   always_comb begin
      w_act_nxt   = (w_next == S_RUN) ? w_onehot : '0;
      w_start_nxt = (w_next == S_RUN && r_state != S_RUN) ?
                    w_onehot : '0;
      w_lock_nxt  = r_lock;
      if (r_state == S_IDLE || r_state == S_COOL)
         w_lock_nxt = r_lock & sw_req;
      if (r_state == S_RUN && w_next == S_COOL)
         w_lock_nxt = r_lock | w_onehot;
      cur_task = (r_state == S_ARM || r_state == S_RUN) ?
                 r_cur : '0;
      arming   = (r_state == S_ARM);
      busy     = (r_state != S_IDLE);
   end

   // Prescaler, tick counter, lock mask, candidate and output registers
   always_ff @(posedge Master_Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_presc  <= '0;
         r_cnt    <= '0;
         r_lock   <= '0;
         r_cur    <= '0;
         r_active <= '0;
         r_start  <= '0;
      end else begin
         if (w_enter || w_tick)
            r_presc <= '0;
         else
            r_presc <= r_presc + PW'(1);
         if (w_enter)
            r_cnt <= '0;
         else if ((r_state == S_ARM || r_state == S_COOL) && w_tick)
            r_cnt <= r_cnt + CW'(1);
         if (r_state == S_IDLE && w_found)
            r_cur <= w_cand;
         r_lock   <= w_lock_nxt;
         r_active <= w_act_nxt;
         r_start  <= w_start_nxt;
      end
   end

`ifdef ROUND_ROBIN_EN
   // Fairness pointer advances past each granted task
   always_ff @(posedge Master_Clock or negedge Reset_n) begin
      if (!Reset_n)
         r_ptr <= '0;
      else if (r_state == S_ARM && w_next == S_RUN)
         r_ptr <= (r_cur == IW'(NUM_TASKS - 1)) ? '0 : r_cur + 1'b1;
   end
`endif

   assign task_active = r_active;
   assign task_start  = r_start;

endmodule
